// File: rtl/revaluate_pkg.sv
// Shared types and constants for the revaluate (chi row step) encoder/decoder stages.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: lane/address widths, row and plane counts, controller state encoding,
//           and the forward row step chi_row.
package revaluate_pkg;

  localparam int LANE_W = 64;
  localparam int ADDR_W = 5;
  localparam int ROW_W  = 5;
  localparam int PLANES = 5;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    COMPUTE,
    WRITE,
    DONE
  } state_t;

  // Forward row step: b[x] = a[x] ^ (~a[x+1] & a[x+2]), indices mod 5.
  function automatic logic [ROW_W-1:0] chi_row(input logic [ROW_W-1:0] a);
    logic [ROW_W-1:0] b;
    b = '0;
    for (int x = 0; x < ROW_W; x++) begin
      b[x] = a[x] ^ (~a[(x + 1) % ROW_W] & a[(x + 2) % ROW_W]);
    end
    return b;
  endfunction

endpackage

// File: rtl/revaluate_inverse_if.sv
// Bundle between the inverse row-step engine, its sequencer and the shared state RAM.
// Latency: n/a (wires only).
// Backpressure: none; start is a one-shot request, the RAM is always ready.
// Ports: start/busy/finish handshake; mem_raddr -> mem_rdata (1-cycle read);
//        mem_we/mem_waddr/mem_wdata write port.
interface revaluate_inverse_if #(
  parameter int LANE_W = revaluate_pkg::LANE_W,
  parameter int ADDR_W = revaluate_pkg::ADDR_W
);

  logic              start;
  logic              busy;
  logic              finish;
  logic [ADDR_W-1:0] mem_raddr;
  logic [LANE_W-1:0] mem_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [LANE_W-1:0] mem_wdata;

  // Engine side.
  modport slave (
    input  start,
    input  mem_rdata,
    output busy,
    output finish,
    output mem_raddr,
    output mem_we,
    output mem_waddr,
    output mem_wdata
  );

  // Sequencer / RAM side.
  modport master (
    output start,
    output mem_rdata,
    input  busy,
    input  finish,
    input  mem_raddr,
    input  mem_we,
    input  mem_waddr,
    input  mem_wdata
  );

endinterface

// File: rtl/revaluate_inverse_inv_chi_row.sv
// Inverse of the 5-bit chi row step, one bit-slice of a plane.
// Latency: combinational.
// Backpressure: none.
// Ports: row_in = {a4..a0} after chi, row_out = the unique preimage.
module inv_chi_row
  import revaluate_pkg::*;
(
  input  logic [ROW_W-1:0] row_in,
  output logic [ROW_W-1:0] row_out
);

  localparam int NUM_ROWS = 1 << ROW_W;

  // chi_row is a bijection on 5 bits, so scattering v into slot chi_row(v)
  // fills all 32 slots exactly once and yields the inverse table.
  function automatic logic [NUM_ROWS*ROW_W-1:0] build_inv_tbl();
    logic [NUM_ROWS*ROW_W-1:0] t;
    t = '0;
    for (int v = 0; v < NUM_ROWS; v++) begin
      t[int'(chi_row(ROW_W'(v)))*ROW_W +: ROW_W] = ROW_W'(v);
    end
    return t;
  endfunction

  localparam logic [NUM_ROWS*ROW_W-1:0] INV_TBL = build_inv_tbl();

  assign row_out = INV_TBL[int'(row_in)*ROW_W +: ROW_W];

endmodule

// File: rtl/revaluate_inverse_top.sv
// Decoder-side inverse of the chi row step over a 5x5xLANE_W state, rewritten in place.
// Latency: 12 cycles per plane; finish pulses 61 cycles after the start edge.
// Backpressure: start is only sampled in IDLE; requests while busy or in DONE are dropped.
// Ports: clk, rst_n (async, active-low); bus.slave carries start/busy/finish and the
//        state RAM read (1-cycle latency) and write ports.
module revaluate_inverse_top #(
  parameter int LANE_W = revaluate_pkg::LANE_W,
  parameter int ADDR_W = revaluate_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  revaluate_inverse_if.slave bus
);

  import revaluate_pkg::*;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        x;
  logic [2:0]        y;
  logic              x_last;
  logic              y_last;
  logic              finish_q;
  logic [ADDR_W-1:0] addr;

  // Read-capture pipeline: the RAM answers one cycle after the address.
  logic              rd_vld;
  logic [2:0]        rd_idx;

  logic [LANE_W-1:0] r     [ROW_W];
  logic [LANE_W-1:0] r_inv [ROW_W];
  logic [LANE_W-1:0][ROW_W-1:0] slice_in;
  logic [LANE_W-1:0][ROW_W-1:0] slice_out;

  assign x_last = (x == 3'd4);
  assign y_last = (y == 3'd4);
  assign addr   = ADDR_W'(y) * ADDR_W'(ROW_W) + ADDR_W'(x);

  // ---------------- controller: state register and lane/plane counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      x        <= '0;
      y        <= '0;
      finish_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      // Registered so finish lands in the first IDLE cycle, together with busy falling.
      finish_q <= (state == DONE);
      case (state)
        IDLE, DONE: begin
          x <= '0;
          y <= '0;
        end
        READ: begin
          x <= x_last ? 3'd0 : x + 3'd1;
        end
        WRITE: begin
          x <= x_last ? 3'd0 : x + 3'd1;
          if (x_last) begin
            y <= y_last ? 3'd0 : y + 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------- controller: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = READ;
      READ:    if (x_last)    state_nxt = WAIT;
      WAIT:    state_nxt = COMPUTE;
      COMPUTE: state_nxt = WRITE;
      WRITE:   if (x_last)    state_nxt = y_last ? DONE : READ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- controller: outputs
  always_comb begin
    bus.busy      = (state != IDLE);
    bus.finish    = finish_q;
    bus.mem_we    = (state == WRITE);
    bus.mem_raddr = (state == READ)  ? addr : '0;
    bus.mem_waddr = (state == WRITE) ? addr : '0;
    bus.mem_wdata = '0;
    if (state == WRITE) begin
      for (int i = 0; i < ROW_W; i++) begin
        if (x == 3'(i)) bus.mem_wdata = r[i];
      end
    end
  end

  // ---------------- datapath: transpose lanes into 5-bit slices and back
  always_comb begin
    slice_in = '0;
    for (int z = 0; z < LANE_W; z++) begin
      for (int i = 0; i < ROW_W; i++) begin
        slice_in[z][i] = r[i][z];
      end
    end
  end

  for (genvar z = 0; z < LANE_W; z++) begin : g_slice
    inv_chi_row u_inv (
      .row_in  (slice_in[z]),
      .row_out (slice_out[z])
    );
  end

  always_comb begin
    for (int i = 0; i < ROW_W; i++) begin
      r_inv[i] = '0;
    end
    for (int z = 0; z < LANE_W; z++) begin
      for (int i = 0; i < ROW_W; i++) begin
        r_inv[i][z] = slice_out[z][i];
      end
    end
  end

  // ---------------- datapath: row buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld <= 1'b0;
      rd_idx <= '0;
      for (int i = 0; i < ROW_W; i++) begin
        r[i] <= '0;
      end
    end else begin
      rd_vld <= (state == READ);
      rd_idx <= x;
      if (rd_vld) begin
        for (int i = 0; i < ROW_W; i++) begin
          if (rd_idx == 3'(i)) r[i] <= bus.mem_rdata;
        end
      end
      if (state == COMPUTE) begin
        for (int i = 0; i < ROW_W; i++) begin
          r[i] <= r_inv[i];
        end
      end
    end
  end

endmodule
